formula_1_sched: RTL and testbench

FORMULA_1_SCHED -- requirements
Module: formula_1_sched

---
 rtl/formula_1_sched_if.sv | 36 +++
 rtl/formula_1_sched.sv | 153 +++++++++++++++
 tb/tb_formula_1_sched.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/formula_1_sched_if.sv
// Handshake/bus bundle for formula_1_sched: argument input, shared isqrt issue/return, result.
// Pure wiring, no latency of its own.
// Backpressure is carried by arg_rdy; the isqrt and result sides are fire-and-forget strobes.
interface formula_1_sched_if #(
  parameter int W = 32
);
  logic           arg_vld;
  logic           arg_rdy;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [W-1:0]   c;
  logic           sq_x_vld;
  logic [W-1:0]   sq_x;
  logic           sq_y_vld;
  logic [W/2-1:0] sq_y;
  logic           res_vld;
  logic [W-1:0]   res;

  // Environment side: supplies arguments, models the isqrt, consumes results.
  modport master (
    output arg_vld, a, b, c,
    input  arg_rdy,
    input  sq_x_vld, sq_x,
    output sq_y_vld, sq_y,
    input  res_vld, res
  );

  // Scheduler side.
  modport slave (
    input  arg_vld, a, b, c,
    output arg_rdy,
    output sq_x_vld, sq_x,
    input  sq_y_vld, sq_y,
    output res_vld, res
  );
endinterface

// File: rtl/formula_1_sched.sv
// Computes isqrt(a)+isqrt(b)+isqrt(c) by time-sharing one pipelined isqrt across the three operands.
// Latency: accept at cycle t -> res_vld at t+4+L, where L is the isqrt latency.
// Backpressure: arg_rdy drops for two cycles after each accept (one set per 3 cycles); results are not stallable.
// Option macro FORMULA_1_SCHED_OPERAND_HOLD_EN: sq_x holds its last operand while idle instead of returning to 0.
module formula_1_sched #(
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              rst,
  formula_1_sched_if.slave  bus
);

  localparam int HW = W / 2;

  // Issue FSM encoding; each active state names the operand on sq_x in that cycle.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] S_A  = 2'd1;
  localparam logic [1:0] S_B  = 2'd2;
  localparam logic [1:0] S_C  = 2'd3;

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic         accept;

`ifndef FORMULA_1_SCHED_OPERAND_HOLD_EN
  logic [W-1:0] op_a;
`endif
  logic [W-1:0] op_b;
  logic [W-1:0] op_c;

  // Ready depends only on state so the upstream never sees a combinational loop through arg_vld.
  assign bus.arg_rdy  = (state == IDLE) || (state == S_C);
  assign accept       = bus.arg_vld && bus.arg_rdy;
  assign bus.sq_x_vld = (state != IDLE);

  // Next-state logic: A->B->C unconditionally, C chains straight into the next set on accept.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? S_A : IDLE;
      S_A:     state_nxt = S_B;
      S_B:     state_nxt = S_C;
      S_C:     state_nxt = accept ? S_A : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the whole argument set at accept so later input changes cannot leak into an issued set.
  always_ff @(posedge clk) begin
    if (rst) begin
`ifndef FORMULA_1_SCHED_OPERAND_HOLD_EN
      op_a <= '0;
`endif
      op_b <= '0;
      op_c <= '0;
    end else if (accept) begin
`ifndef FORMULA_1_SCHED_OPERAND_HOLD_EN
      op_a <= bus.a;
`endif
      op_b <= bus.b;
      op_c <= bus.c;
    end
  end

`ifdef FORMULA_1_SCHED_OPERAND_HOLD_EN
  logic [W-1:0] sq_x_q;

  // Registered operand: loaded with the operand of the upcoming active state, held otherwise.
  // 'a' is taken straight from the input on accept since op_* only become valid in S_A.
  always_ff @(posedge clk) begin
    if (rst) begin
      sq_x_q <= '0;
    end else if (accept) begin
      sq_x_q <= bus.a;
    end else if (state == S_A) begin
      sq_x_q <= op_b;
    end else if (state == S_B) begin
      sq_x_q <= op_c;
    end
  end

  assign bus.sq_x = sq_x_q;
`else
  logic [W-1:0] sq_x_mux;

  // Operand select; forced to zero when nothing is issued.
  always_comb begin
    sq_x_mux = '0;
    case (state)
      S_A:     sq_x_mux = op_a;
      S_B:     sq_x_mux = op_b;
      S_C:     sq_x_mux = op_c;
      default: sq_x_mux = '0;
    endcase
  end

  assign bus.sq_x = sq_x_mux;
`endif

  // Return side: driven only by sq_y_vld, so it runs independently of (and concurrently with) issue.
  logic [1:0]   rp;
  logic [W-1:0] acc;
  logic [W-1:0] res_q;
  logic         res_vld_q;
  logic [W-1:0] sq_y_ext;

  assign sq_y_ext = {{(W - HW){1'b0}}, bus.sq_y};

  // Accumulate three in-order returns; the third produces a one-cycle result strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rp        <= 2'd0;
      acc       <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      res_vld_q <= 1'b0;
      if (bus.sq_y_vld) begin
        case (rp)
          2'd0: begin
            acc <= sq_y_ext;
            rp  <= 2'd1;
          end
          2'd1: begin
            acc <= acc + sq_y_ext;
            rp  <= 2'd2;
          end
          2'd2: begin
            res_q     <= acc + sq_y_ext;
            res_vld_q <= 1'b1;
            rp        <= 2'd0;
          end
          default: begin
            rp <= 2'd0;
          end
        endcase
      end
    end
  end

  assign bus.res     = res_q;
  assign bus.res_vld = res_vld_q;

endmodule

// File: tb/tb_formula_1_sched.sv
// Directed bench for formula_1_sched with a behavioural pipelined isqrt of latency L.
module tb_formula_1_sched;

  localparam int W = 32;
  localparam int L = 2;

`ifdef FORMULA_1_SCHED_OPERAND_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  formula_1_sched_if #(.W(W)) bus ();

  formula_1_sched #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W/2-1:0] isqrt(input logic [W-1:0] v);
    logic [63:0] r;
    logic [63:0] cand;
    logic [63:0] vv;
    r  = 64'd0;
    vv = 64'(v);
    for (int i = W/2 - 1; i >= 0; i--) begin
      cand = r | (64'd1 << i);
      if (cand * cand <= vv) r = cand;
    end
    return r[W/2-1:0];
  endfunction

  // Shared isqrt model, reset together with the scheduler.
  logic [L-1:0]   pv;
  logic [W/2-1:0] pd [L];
  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv[0] <= bus.sq_x_vld;
      pd[0] <= isqrt(bus.sq_x);
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end
  assign bus.sq_y_vld = pv[L-1];
  assign bus.sq_y     = pd[L-1];

  // Result log: value and cycle of every res_vld pulse.
  logic [W-1:0] rq_val[$];
  int           rq_cyc[$];
  always @(posedge clk) begin
    #1;
    if (bus.res_vld === 1'b1) begin
      rq_val.push_back(bus.res);
      rq_cyc.push_back(cyc);
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.arg_vld = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.arg_rdy, bus.sq_x_vld, bus.res_vld} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctl: got rdy/xvld/rvld=%b expected 100", {bus.arg_rdy, bus.sq_x_vld, bus.res_vld});
    end
    checks++;
    if (bus.res !== '0) begin
      errors++;
      $display("FAIL reset_res: got %0d expected 0", bus.res);
    end
    checks++;
    if (bus.sq_x !== '0) begin
      errors++;
      $display("FAIL reset_sqx: got %0d expected 0", bus.sq_x);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int t;
    rq_val.delete(); rq_cyc.delete();
    checks++;
    if (bus.arg_rdy !== 1'b1) begin
      errors++;
      $display("FAIL single_idle_rdy: got %b expected 1", bus.arg_rdy);
    end
    bus.a = 32'd16; bus.b = 32'd81; bus.c = 32'd1; bus.arg_vld = 1'b1;
    t = cyc;
    @(negedge clk);
    bus.arg_vld = 1'b0;
    checks++;
    if ({bus.sq_x_vld, bus.arg_rdy, bus.sq_x} !== {1'b1, 1'b0, 32'd16}) begin
      errors++;
      $display("FAIL single_sa: got vld=%b rdy=%b x=%0d expected 1 0 16", bus.sq_x_vld, bus.arg_rdy, bus.sq_x);
    end
    @(negedge clk);
    checks++;
    if ({bus.sq_x_vld, bus.arg_rdy, bus.sq_x} !== {1'b1, 1'b0, 32'd81}) begin
      errors++;
      $display("FAIL single_sb: got vld=%b rdy=%b x=%0d expected 1 0 81", bus.sq_x_vld, bus.arg_rdy, bus.sq_x);
    end
    @(negedge clk);
    checks++;
    if ({bus.sq_x_vld, bus.arg_rdy, bus.sq_x} !== {1'b1, 1'b1, 32'd1}) begin
      errors++;
      $display("FAIL single_sc: got vld=%b rdy=%b x=%0d expected 1 1 1", bus.sq_x_vld, bus.arg_rdy, bus.sq_x);
    end
    @(negedge clk);
    checks++;
    if ({bus.sq_x_vld, bus.arg_rdy} !== 2'b01) begin
      errors++;
      $display("FAIL single_back_idle: got vld=%b rdy=%b expected 0 1", bus.sq_x_vld, bus.arg_rdy);
    end
    for (int k = 0; k < 40 && rq_val.size() < 1; k++) @(negedge clk);
    checks++;
    if (rq_val.size() != 1) begin
      errors++;
      $display("FAIL single_count: got %0d results expected 1", rq_val.size());
    end
    if (rq_val.size() >= 1) begin
      checks++;
      if (rq_val[0] !== 32'd14) begin
        errors++;
        $display("FAIL single_res: got %0d expected 14", rq_val[0]);
      end
      checks++;
      if (rq_cyc[0] != t + 4 + L) begin
        errors++;
        $display("FAIL single_latency: got cycle %0d expected %0d", rq_cyc[0], t + 4 + L);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.res_vld, bus.res} !== {1'b0, 32'd14}) begin
      errors++;
      $display("FAIL single_hold: got vld=%b res=%0d expected 0 14", bus.res_vld, bus.res);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    int j;
    rq_val.delete(); rq_cyc.delete();
    t0 = cyc;
    j = 0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (bus.arg_rdy !== ((i % 3) == 0)) begin
        errors++;
        $display("FAIL b2b_rdy_%0d: got %b expected %b", i, bus.arg_rdy, ((i % 3) == 0));
      end
      bus.a = 32'((j + 1) * (j + 1));
      bus.b = 32'((j + 2) * (j + 2));
      bus.c = 32'((j + 3) * (j + 3));
      bus.arg_vld = 1'b1;
      if (bus.arg_rdy === 1'b1) j++;
      @(negedge clk);
    end
    bus.arg_vld = 1'b0;
    checks++;
    if (j != 4) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d expected 4", j);
    end
    for (int k = 0; k < 40 && rq_val.size() < 4; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (rq_val.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d results expected 4", rq_val.size());
    end
    for (int k = 0; k < 4 && k < rq_val.size(); k++) begin
      checks++;
      if (rq_val[k] !== 32'(6 + 3 * k)) begin
        errors++;
        $display("FAIL b2b_res_%0d: got %0d expected %0d", k, rq_val[k], 6 + 3 * k);
      end
      checks++;
      if (rq_cyc[k] != t0 + 4 + L + 3 * k) begin
        errors++;
        $display("FAIL b2b_cycle_%0d: got %0d expected %0d", k, rq_cyc[k], t0 + 4 + L + 3 * k);
      end
    end
  endtask

  task automatic test_max();
    rq_val.delete(); rq_cyc.delete();
    bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.c = 32'hFFFF_FFFF; bus.arg_vld = 1'b1;
    @(negedge clk);
    bus.arg_vld = 1'b0;
    for (int k = 0; k < 40 && rq_val.size() < 1; k++) @(negedge clk);
    checks++;
    if (rq_val.size() != 1) begin
      errors++;
      $display("FAIL max_count: got %0d results expected 1", rq_val.size());
    end else begin
      checks++;
      if (rq_val[0] !== 32'h0002_FFFD) begin
        errors++;
        $display("FAIL max_res: got %0d expected 196605", rq_val[0]);
      end
    end
    checks++;
    if (bus.sq_x !== (HOLD ? 32'hFFFF_FFFF : 32'd0)) begin
      errors++;
      $display("FAIL idle_sqx: got %h expected %h", bus.sq_x, (HOLD ? 32'hFFFF_FFFF : 32'd0));
    end
  endtask

  task automatic test_capture();
    rq_val.delete(); rq_cyc.delete();
    bus.a = 32'd25; bus.b = 32'd36; bus.c = 32'd49; bus.arg_vld = 1'b1;
    @(negedge clk);
    bus.arg_vld = 1'b0;
    checks++;
    if (bus.sq_x !== 32'd25) begin
      errors++;
      $display("FAIL capture_sa: got %0d expected 25", bus.sq_x);
    end
    bus.a = $urandom; bus.b = $urandom; bus.c = $urandom;
    @(negedge clk);
    checks++;
    if (bus.sq_x !== 32'd36) begin
      errors++;
      $display("FAIL capture_sb: got %0d expected 36", bus.sq_x);
    end
    bus.a = $urandom; bus.b = $urandom; bus.c = $urandom;
    @(negedge clk);
    checks++;
    if (bus.sq_x !== 32'd49) begin
      errors++;
      $display("FAIL capture_sc: got %0d expected 49", bus.sq_x);
    end
    for (int k = 0; k < 40 && rq_val.size() < 1; k++) @(negedge clk);
    checks++;
    if (rq_val.size() != 1) begin
      errors++;
      $display("FAIL capture_count: got %0d results expected 1", rq_val.size());
    end else begin
      checks++;
      if (rq_val[0] !== 32'd18) begin
        errors++;
        $display("FAIL capture_res: got %0d expected 18", rq_val[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    rq_val.delete(); rq_cyc.delete();
    bus.a = 32'd100; bus.b = 32'd100; bus.c = 32'd100; bus.arg_vld = 1'b1;
    @(negedge clk);
    bus.arg_vld = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.arg_rdy, bus.sq_x_vld, bus.sq_x} !== {1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL rstmid_state: got rdy=%b vld=%b x=%0d expected 1 0 0", bus.arg_rdy, bus.sq_x_vld, bus.sq_x);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (rq_val.size() != 0) begin
      errors++;
      $display("FAIL rstmid_no_res: got %0d results expected 0", rq_val.size());
    end
    bus.a = 32'd4; bus.b = 32'd9; bus.c = 32'd16; bus.arg_vld = 1'b1;
    t = cyc;
    @(negedge clk);
    bus.arg_vld = 1'b0;
    for (int k = 0; k < 40 && rq_val.size() < 1; k++) @(negedge clk);
    checks++;
    if (rq_val.size() != 1) begin
      errors++;
      $display("FAIL rstmid_count: got %0d results expected 1", rq_val.size());
    end else begin
      checks++;
      if (rq_val[0] !== 32'd9) begin
        errors++;
        $display("FAIL rstmid_res: got %0d expected 9", rq_val[0]);
      end
      checks++;
      if (rq_cyc[0] != t + 4 + L) begin
        errors++;
        $display("FAIL rstmid_latency: got cycle %0d expected %0d", rq_cyc[0], t + 4 + L);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_max();
    test_capture();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
